// File: rtl/store_pkg.sv
// Shared definitions for the store path: FSM state encoding, access-size
// codes and the alignment rule used to reject illegal store requests.
package store_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      FIN  = 3'd4
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // True when the request cannot be served: half on an odd byte, word off a
   // word boundary, or the reserved size code.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
      logic r;
      case (size)
         SZ_BYTE: r = 1'b0;
         SZ_HALF: r = off[0];
         SZ_WORD: r = (off != 2'b00);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// lane_merge: combinational little-endian lane insertion. The new byte or
// halfword replaces its lane in the old word; every other bit is preserved.
module lane_merge
   import store_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_old,
   input  logic [WIDTH-1:0] i_new,
   input  logic [1:0]       i_size,
   input  logic [1:0]       i_off,
   output logic [WIDTH-1:0] o_merged
);

   // Overlay the selected lane onto the old word.
   always_comb begin
      o_merged = i_old;
      case (i_size)
         SZ_BYTE: begin
            case (i_off)
               2'd0:    o_merged[7:0]   = i_new[7:0];
               2'd1:    o_merged[15:8]  = i_new[7:0];
               2'd2:    o_merged[23:16] = i_new[7:0];
               default: o_merged[31:24] = i_new[7:0];
            endcase
         end
         SZ_HALF: begin
            if (i_off[1]) o_merged[31:16] = i_new[15:0];
            else          o_merged[15:0]  = i_new[15:0];
         end
         SZ_WORD: o_merged = i_new;
         default: o_merged = i_old;
      endcase
   end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: multicycle store path. Narrows a register value to
// byte/half/word and writes it to single-port, synchronous-read data memory,
// using read-modify-write for sub-word stores.
// Optional feature: define STORE_MERGE_OVF_EN to build the narrowing
// overflow check; otherwise Ovf is tied low.
module store_merge_unit
   import store_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Start,
   input  logic [ADDR_W+1:0] Addr,
   input  logic [WIDTH-1:0]  Data,
   input  logic [1:0]        Size,
   input  logic [WIDTH-1:0]  MemRData,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemWE,
   output logic [WIDTH-1:0]  MemWData,
   output logic              Busy,
   output logic              Done,
   output logic              Err,
   output logic              Ovf
);

   state_t              r_state;
   logic [WIDTH-1:0]    r_data;
   logic [1:0]          r_size;
   logic [1:0]          r_off;
   logic [ADDR_W-1:0]   r_addr;
   logic [WIDTH-1:0]    r_wdata;
   logic                r_err;

   logic                w_accept;
   logic                w_misaligned;
   logic [WIDTH-1:0]    w_merged;

   assign w_accept     = (r_state == IDLE) && Start;
   assign w_misaligned = is_misaligned(Size, Addr[1:0]);

   lane_merge #(.WIDTH(WIDTH)) u_lane_merge (
      .i_old    (MemRData),
      .i_new    (r_data),
      .i_size   (r_size),
      .i_off    (r_off),
      .o_merged (w_merged)
   );

   // Capture the request operands when a new store is accepted.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_data <= Data;
         r_size <= Size;
         r_off  <= Addr[1:0];
      end
   end

   // Control FSM: sequences read, merge and write, and owns the memory
   // address/data registers so they hold outside RD and WR.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Start) begin
                  r_err <= w_misaligned;
                  if (w_misaligned) begin
                     r_state <= FIN;
                  end else begin
                     r_addr <= Addr[ADDR_W+1:2];
                     if (Size == SZ_WORD) begin
                        // Full-word store needs no read; data goes out as is.
                        r_wdata <= Data;
                        r_state <= WR;
                     end else begin
                        r_state <= RD;
                     end
                  end
               end
            end
            RD:      r_state <= WAIT;
            WAIT: begin
               // Read data is valid now; register the merged word for WR.
               r_wdata <= w_merged;
               r_state <= WR;
            end
            WR:      r_state <= FIN;
            FIN:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef STORE_MERGE_OVF_EN
   logic r_ovf;

   // A value overflows when its truncated lane does not sign-extend back to
   // the original register value.
   function automatic logic narrow_ovf(input logic [1:0] size,
                                       input logic [WIDTH-1:0] d);
      logic r;
      case (size)
         SZ_BYTE: r = !((&d[WIDTH-1:7])  || (~|d[WIDTH-1:7]));
         SZ_HALF: r = !((&d[WIDTH-1:15]) || (~|d[WIDTH-1:15]));
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Evaluate overflow once at acceptance; rejected requests never flag it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_ovf <= !w_misaligned && narrow_ovf(Size, Data);
      end
   end

   assign Ovf = r_ovf;
`else
   assign Ovf = 1'b0;
`endif

   assign MemWE    = (r_state == WR);
   assign Busy     = (r_state != IDLE);
   assign Done     = (r_state == FIN);
   assign Err      = r_err;
   assign MemAddr  = r_addr;
   assign MemWData = r_wdata;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: directed vectors, two multi-cycle
// corner sequences and randomized stores against a behavioural model.
module tb_store_merge_unit;

   localparam int ADDR_W = 10;
`ifdef STORE_MERGE_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              Start;
   logic [ADDR_W+1:0] Addr;
   logic [31:0]       Data;
   logic [1:0]        Size;
   logic [31:0]       MemRData;
   logic [ADDR_W-1:0] MemAddr;
   logic              MemWE;
   logic [31:0]       MemWData;
   logic              Busy;
   logic              Done;
   logic              Err;
   logic              Ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_merge_unit #(.WIDTH(32), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Start    (Start),
      .Addr     (Addr),
      .Data     (Data),
      .Size     (Size),
      .MemRData (MemRData),
      .MemAddr  (MemAddr),
      .MemWE    (MemWE),
      .MemWData (MemWData),
      .Busy     (Busy),
      .Done     (Done),
      .Err      (Err),
      .Ovf      (Ovf)
   );

   // Word-wide synchronous-read memory with a bench preload port.
   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic              ld_en = 1'b0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic [31:0]       ld_data = '0;

   always @(posedge clk) begin
      MemRData <= mem[MemAddr];
      if (ld_en)      mem[ld_addr] <= ld_data;
      else if (MemWE) mem[MemAddr] <= MemWData;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [ADDR_W-1:0] w, input logic [31:0] v);
      ld_en = 1'b1; ld_addr = w; ld_data = v;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   // Reference behaviour from the store rules, in plain arithmetic.
   function automatic void model(input logic [11:0] a, input logic [1:0] sz,
                                 input logic [31:0] d, input logic [31:0] old,
                                 output logic err, output logic ovf,
                                 output logic [31:0] word,
                                 output int done_cyc, output int we_cyc);
      logic [31:0] mask, sext;
      int sh;
      err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      word = old; ovf = 1'b0;
      if (!err) begin
         if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
            word = (old & ~mask) | ((d & 32'hFF) << sh);
            sext = {{24{d[7]}}, d[7:0]};
            ovf = OVF_ON && (sext != d);
         end else if (sz == 2'b01) begin
            sh = a[1] ? 16 : 0;
            mask = 32'hFFFF << sh;
            word = (old & ~mask) | ((d & 32'hFFFF) << sh);
            sext = {{16{d[15]}}, d[15:0]};
            ovf = OVF_ON && (sext != d);
         end else begin
            word = d;
         end
      end
      done_cyc = err ? 1 : (sz == 2'b10 ? 2 : 4);
      we_cyc   = err ? 0 : (sz == 2'b10 ? 1 : 3);
   endfunction

   // Issue one store from IDLE and observe it until Done (bounded).
   task automatic run_store(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] d,
                            output int done_cyc, output int we_cnt, output int we_cyc,
                            output logic [31:0] we_data, output logic [ADDR_W-1:0] we_addr,
                            output logic err, output logic ovf);
      done_cyc = -1; we_cnt = 0; we_cyc = 0; we_data = '0; we_addr = '0;
      err = 1'b0; ovf = 1'b0;
      Start = 1'b1; Addr = a; Size = sz; Data = d;
      @(posedge clk); #1;
      Start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (MemWE) begin
            we_cnt++; we_cyc = c; we_data = MemWData; we_addr = MemAddr;
         end
         if (Done) begin
            done_cyc = c; err = Err; ovf = Ovf;
         end
         @(posedge clk); #1;
         if (done_cyc > 0) break;
      end
   endtask

   typedef struct {
      logic [11:0] addr;
      logic [1:0]  size;
      logic [31:0] data;
      logic [31:0] init;
      logic [31:0] exp_word;
      logic        exp_err;
      logic        exp_ovf;
      int          exp_done;
      int          exp_we;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int dc, wn, wc, edc, ewc;
      logic [31:0] wd, ew, old, d;
      logic [ADDR_W-1:0] wa;
      logic e, o, ee, eo;
      logic [11:0] a;
      logic [1:0] sz;

      tbl[0] = '{12'h011, 2'b00, 32'h000000EE, 32'hAABBCCDD, 32'hAABBEEDD, 1'b0, 1'b0,   4, 3};
      tbl[1] = '{12'h002, 2'b01, 32'hFFFF8765, 32'h11223344, 32'h87653344, 1'b0, 1'b0,   4, 3};
      tbl[2] = '{12'h008, 2'b10, 32'hDEADBEEF, 32'h01010101, 32'hDEADBEEF, 1'b0, 1'b0,   2, 1};
      tbl[3] = '{12'h003, 2'b01, 32'h00001234, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 1'b0,   1, 0};
      tbl[4] = '{12'h006, 2'b10, 32'h12345678, 32'h0C0FFEE0, 32'h0C0FFEE0, 1'b1, 1'b0,   1, 0};
      tbl[5] = '{12'h020, 2'b00, 32'h00000180, 32'h12345678, 32'h12345680, 1'b0, OVF_ON, 4, 3};
      tbl[6] = '{12'h030, 2'b11, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0,   1, 0};
      tbl[7] = '{12'h013, 2'b00, 32'h0000005A, 32'h11223344, 32'h5A223344, 1'b0, 1'b0,   4, 3};

      rst_n = 1'b0; Start = 1'b0; Addr = '0; Data = '0; Size = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, Busy}, 32'd0);
      chk("reset done_we", {30'd0, Done, MemWE}, 32'd0);
      chk("reset err_ovf", {30'd0, Err, Ovf}, 32'd0);
      chk("reset memaddr", {22'd0, MemAddr}, 32'd0);
      chk("reset memwdata", MemWData, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors
      for (int i = 0; i < 8; i++) begin
         preload(tbl[i].addr[11:2], tbl[i].init);
         run_store(tbl[i].addr, tbl[i].size, tbl[i].data, dc, wn, wc, wd, wa, e, o);
         chk($sformatf("vec%0d done_cyc", i), dc, tbl[i].exp_done);
         chk($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
         chk($sformatf("vec%0d ovf", i), {31'd0, o}, {31'd0, tbl[i].exp_ovf});
         chk($sformatf("vec%0d we_count", i), wn, (tbl[i].exp_we != 0) ? 1 : 0);
         if (tbl[i].exp_we != 0) begin
            chk($sformatf("vec%0d we_cyc", i), wc, tbl[i].exp_we);
            chk($sformatf("vec%0d wdata", i), wd, tbl[i].exp_word);
            chk($sformatf("vec%0d waddr", i), {22'd0, wa}, {22'd0, tbl[i].addr[11:2]});
         end
         chk($sformatf("vec%0d mem", i), mem[tbl[i].addr[11:2]], tbl[i].exp_word);
      end

      // Start pulsed during WAIT must be ignored
      preload(10'd5, 32'h01020304);
      preload(10'h00C, 32'h00000000);
      wn = 0; wd = '0; dc = -1;
      Start = 1'b1; Addr = 12'h015; Size = 2'b00; Data = 32'h00000077;
      @(posedge clk); #1;
      Start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c == 2) begin
            Start = 1'b1; Addr = 12'h030; Size = 2'b10; Data = 32'hCAFEF00D;
         end else begin
            Start = 1'b0;
         end
         if (MemWE) begin wn++; wd = MemWData; end
         if (Done && dc < 0) dc = c;
         @(posedge clk); #1;
      end
      Start = 1'b0;
      chk("ignore_start we_count", wn, 1);
      chk("ignore_start wdata", wd, 32'h01027704);
      chk("ignore_start done_cyc", dc, 4);
      chk("ignore_start other_word", mem[10'h00C], 32'h00000000);

      // Reset asserted during WAIT: no write afterwards, outputs cleared
      preload(10'd6, 32'h55555555);
      Start = 1'b1; Addr = 12'h018; Size = 2'b00; Data = 32'h000000AA;
      @(posedge clk); #1;
      Start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_wait ctrl", {27'd0, Busy, Done, MemWE, Err, Ovf}, 32'd0);
      chk("rst_wait memaddr", {22'd0, MemAddr}, 32'd0);
      chk("rst_wait memwdata", MemWData, 32'd0);
      rst_n = 1'b1;
      wn = 0;
      for (int c = 0; c < 6; c++) begin
         if (MemWE) wn++;
         @(posedge clk); #1;
      end
      chk("rst_wait we_count", wn, 0);
      chk("rst_wait mem", mem[10'd6], 32'h55555555);

      // Randomized stores against the model
      for (int i = 0; i < 150; i++) begin
         a   = 12'($urandom_range(0, 4095));
         sz  = 2'($urandom_range(0, 3));
         old = $urandom;
         case ($urandom_range(0, 2))
            0:       d = $urandom;
            1:       d = {{24{1'($urandom_range(0, 1))}}, 8'($urandom)};
            default: d = {{16{1'($urandom_range(0, 1))}}, 16'($urandom)};
         endcase
         preload(a[11:2], old);
         model(a, sz, d, old, ee, eo, ew, edc, ewc);
         run_store(a, sz, d, dc, wn, wc, wd, wa, e, o);
         chk($sformatf("rnd%0d done_cyc", i), dc, edc);
         chk($sformatf("rnd%0d err", i), {31'd0, e}, {31'd0, ee});
         chk($sformatf("rnd%0d ovf", i), {31'd0, o}, {31'd0, eo});
         chk($sformatf("rnd%0d we_count", i), wn, ee ? 0 : 1);
         if (!ee) begin
            chk($sformatf("rnd%0d we_cyc", i), wc, ewc);
            chk($sformatf("rnd%0d wdata", i), wd, ew);
            chk($sformatf("rnd%0d waddr", i), {22'd0, wa}, {22'd0, a[11:2]});
         end
         chk($sformatf("rnd%0d mem", i), mem[a[11:2]], ew);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
